// File: rtl/song_reader_poly.sv
// rtl/song_reader_poly.sv - multi-voice song ROM sequencer with beat-counted rests
// Optional feature macro: SONG_READER_END_MARKER_EN (zero-duration rest ends the song)
module song_reader_poly #(
    parameter int SONG_BITS = 2,
    parameter int ADDR_BITS = 5,
    parameter int NOTE_W    = 6,
    parameter int DUR_W     = 6,
    parameter int VOICE_W   = 2,
    parameter int VOICES    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          beat,
    output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
    input  logic [VOICE_W+NOTE_W+DUR_W:0] rom_data,
    output logic [VOICES*NOTE_W-1:0]      note_bus,
    output logic [VOICES*DUR_W-1:0]       dur_bus,
    output logic [VOICES-1:0]             new_note,
    output logic                          song_done,
    output logic                          playing,
    output logic [ADDR_BITS-1:0]          ptr
);

    localparam int ENTRY_W = 1 + VOICE_W + NOTE_W + DUR_W;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_BITS-1:0]           ptr_q, ptr_d;
    logic [SONG_BITS-1:0]           song_q, song_d;
    logic [DUR_W-1:0]               cnt_q, cnt_d;
    logic [VOICES*NOTE_W-1:0]       note_q, note_d;
    logic [VOICES*DUR_W-1:0]        dur_q, dur_d;
    logic [VOICES-1:0]              new_note_q, new_note_d;
    logic                           song_done_q, song_done_d;
    logic [SONG_BITS+ADDR_BITS-1:0] rom_addr_q;
    logic                           step, finish;

    logic                           ent_adv;
    logic [VOICE_W-1:0]             ent_voice;
    logic [NOTE_W-1:0]              ent_note;
    logic [DUR_W-1:0]               ent_dur;

    assign ent_adv   = rom_data[ENTRY_W-1];
    assign ent_voice = rom_data[NOTE_W+DUR_W +: VOICE_W];
    assign ent_note  = rom_data[DUR_W +: NOTE_W];
    assign ent_dur   = rom_data[DUR_W-1:0];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        song_d      = song_q;
        cnt_d       = cnt_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = '0;
        song_done_d = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;

        // A song change restarts the new song; it only stays paused if paused with play low.
        if (song != song_q) begin
            ptr_d   = '0;
            cnt_d   = '0;
            song_d  = song;
            state_d = (state_q == PAUSED && !play) ? PAUSED : FETCH;
        end else if (!play) begin
            state_d = PAUSED;
        end else begin
            case (state_q)
                PAUSED: state_d = (cnt_q != '0) ? WAIT : FETCH;
                FETCH:  state_d = DECODE;
                DECODE: begin
                    if (!ent_adv) begin
                        for (int v = 0; v < VOICES; v++) begin
                            if (ent_voice == VOICE_W'(v)) begin
                                note_d[v*NOTE_W +: NOTE_W] = ent_note;
                                dur_d[v*DUR_W +: DUR_W]    = ent_dur;
                                new_note_d[v]              = 1'b1;
                            end
                        end
                        step = 1'b1;
                    end else if (ent_dur != '0) begin
                        cnt_d   = ent_dur;
                        state_d = WAIT;
                    end else begin
`ifdef SONG_READER_END_MARKER_EN
                        finish = 1'b1;
`else
                        step = 1'b1;
`endif
                    end
                end
                WAIT: begin
                    if (beat) begin
                        if (cnt_q <= DUR_W'(1)) begin
                            cnt_d = '0;
                            step  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - DUR_W'(1);
                        end
                    end
                end
                default: state_d = PAUSED;
            endcase
        end

        if (finish || (step && ptr_q == '1)) begin
            ptr_d       = '0;
            song_done_d = 1'b1;
            state_d     = PAUSED;
        end else if (step) begin
            ptr_d   = ptr_q + ADDR_BITS'(1);
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= PAUSED;
            ptr_q       <= '0;
            song_q      <= song;
            cnt_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= '0;
            song_done_q <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            song_q      <= song_d;
            cnt_q       <= cnt_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
            rom_addr_q  <= {song_d, ptr_d};
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note_bus  = note_q;
    assign dur_bus   = dur_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;
    assign playing   = (state_q != PAUSED);
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_song_reader_poly.sv
// tb/tb_song_reader_poly.sv - self-checking bench for song_reader_poly
module tb_song_reader_poly;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset, play, beat;
    logic [1:0]  song;
    logic [6:0]  rom_addr;
    logic [14:0] rom_data;
    logic [17:0] note_bus;
    logic [17:0] dur_bus;
    logic [2:0]  new_note;
    logic        song_done, playing;
    logic [4:0]  ptr;

    logic [14:0] rom [0:127];

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_nn    [MAXC];
    int         exp_vi    [MAXC];
    int         exp_nv    [MAXC];
    int         exp_dv    [MAXC];
    int         exp_fetch [MAXC];
    logic       sched     [MAXC];

    song_reader_poly dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .beat      (beat),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_bus  (note_bus),
        .dur_bus   (dur_bus),
        .new_note  (new_note),
        .song_done (song_done),
        .playing   (playing),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [14:0] rnd_entry(input int rest_pct);
        logic       adv;
        logic [1:0] vo;
        logic [5:0] nt, du;
        adv = ($urandom_range(99) < 32'(rest_pct));
        vo  = 2'($urandom_range(3));
        nt  = 6'($urandom_range(63));
        du  = adv ? 6'($urandom_range(4)) : 6'($urandom_range(63));
        return {adv, vo, nt, du};
    endfunction

    // Expected timeline from the entry rules: a note takes 2 cycles and strobes as the
    // next fetch starts; a rest resumes the cycle after its duration-th beat past DECODE.
    task automatic run_song(input int s);
        int          t, c, n, done_c;
        logic [14:0] en;
        play = 1'b0; beat = 1'b0;
        tick();
        song = 2'(s);
        tick();
        for (int i = 0; i < MAXC; i++) begin
            exp_nn[i] = '0; exp_vi[i] = 0; exp_nv[i] = 0; exp_dv[i] = 0; exp_fetch[i] = 0;
            sched[i] = ($urandom_range(2) == 0);
        end
        t = 0; done_c = -1;
        for (int e = 0; e < 32; e++) begin
            en = rom[7'(s*32 + e)];
            exp_fetch[t] = e + 1;
            if (!en[14]) begin
                if (en[13:12] < 2'd3) begin
                    exp_nn[t+2] = 3'(3'b001 << en[13:12]);
                    exp_vi[t+2] = int'(en[13:12]);
                    exp_nv[t+2] = int'(en[11:6]);
                    exp_dv[t+2] = int'(en[5:0]);
                end
                t = t + 2;
            end else if (en[5:0] == 6'd0) begin
`ifdef SONG_READER_END_MARKER_EN
                done_c = t + 2;
                break;
`else
                t = t + 2;
`endif
            end else begin
                n = 0; c = t + 1;
                while (n < int'(en[5:0]) && c < MAXC - 8) begin
                    c++;
                    if (sched[c]) n++;
                end
                t = c + 1;
            end
        end
        if (done_c < 0) done_c = t;
        play = 1'b1;
        tick();
        for (int cy = 0; cy <= done_c && cy < MAXC; cy++) begin
            chk("new_note", 32'(new_note), 32'(exp_nn[cy]));
            chk("song_done", 32'(song_done), 32'(cy == done_c));
            chk("playing", 32'(playing), 32'(cy != done_c));
            if (exp_nn[cy] != 3'd0) begin
                chk("note_bus", 32'(note_bus[exp_vi[cy]*6 +: 6]), 32'(exp_nv[cy]));
                chk("dur_bus", 32'(dur_bus[exp_vi[cy]*6 +: 6]), 32'(exp_dv[cy]));
            end
            if (exp_fetch[cy] != 0)
                chk("rom_addr", 32'(rom_addr), 32'(s*32 + exp_fetch[cy] - 1));
            if (cy == done_c) begin
                chk("end_ptr", 32'(ptr), 32'd0);
                play = 1'b0;
            end
            beat = sched[cy];
            tick();
        end
        beat = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = rnd_entry(25);
        // song 1: chord on three voices then a 4-beat rest
        rom[32] = {1'b0, 2'd0, 6'd12, 6'd8};
        rom[33] = {1'b0, 2'd1, 6'd16, 6'd8};
        rom[34] = {1'b0, 2'd2, 6'd19, 6'd8};
        rom[35] = {1'b1, 2'd0, 6'd0,  6'd4};
        rom[64+5] = {1'b1, 2'd0, 6'd0, 6'd0};
        for (int i = 0; i < 32; i++) rom[i] = rnd_entry(0);
        rom[96] = {1'b1, 2'd0, 6'd0, 6'd4};
        rom[97] = {1'b1, 2'd0, 6'd0, 6'd3};

        reset = 1'b0; play = 1'b1; song = 2'd1; beat = 1'b0;
        tick(); tick(); tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_note_bus", 32'(note_bus), 32'd0);
        chk("rst_dur_bus", 32'(dur_bus), 32'd0);
        chk("rst_new_note", 32'(new_note), 32'd0);
        chk("rst_song_done", 32'(song_done), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'd0);
        reset = 1'b1;
        tick();
        chk("first_rom_addr", 32'(rom_addr), 32'h20);
        chk("first_playing", 32'(playing), 32'd1);
        play = 1'b0;
        tick();

        run_song(1);
        run_song(2);
        run_song(0);

        // pause in the middle of a 4-beat rest
        play = 1'b0; beat = 1'b0;
        tick();
        song = 2'd3;
        tick();
        play = 1'b1;
        tick();
        chk("p_fetch_addr", 32'(rom_addr), 32'h60);
        tick(); tick();
        beat = 1'b1; tick(); tick();
        beat = 1'b0; play = 1'b0;
        tick();
        chk("p_paused", 32'(playing), 32'd0);
        chk("p_ptr_held", 32'(ptr), 32'd0);
        beat = 1'b1; tick(); tick();
        beat = 1'b0; play = 1'b1;
        tick();
        chk("p_resumed", 32'(playing), 32'd1);
        beat = 1'b1;
        tick();
        chk("p_one_left_ptr", 32'(ptr), 32'd0);
        chk("p_one_left_addr", 32'(rom_addr), 32'h60);
        tick();
        chk("p_step_ptr", 32'(ptr), 32'd1);
        chk("p_step_addr", 32'(rom_addr), 32'h61);
        beat = 1'b0;

        // song change while waiting on a rest
        rom[64] = {1'b0, 2'd0, 6'd33, 6'd7};
        tick(); tick();
        beat = 1'b1; tick();
        beat = 1'b0; song = 2'd2;
        tick();
        chk("sc_rom_addr", 32'(rom_addr), 32'h40);
        chk("sc_ptr", 32'(ptr), 32'd0);
        chk("sc_song_done", 32'(song_done), 32'd0);
        chk("sc_playing", 32'(playing), 32'd1);
        play = 1'b0;
        tick();
        play = 1'b1;
        tick();
        chk("sc_refetch_addr", 32'(rom_addr), 32'h40);
        tick(); tick();
        chk("sc_cnt_cleared_strobe", 32'(new_note), 32'd1);
        chk("sc_note", 32'(note_bus[5:0]), 32'd33);
        play = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
